// File: rtl/bitmanip_exec_unit.sv
// Bit-manipulation execute unit with an iterative restoring divider; single-cycle ops in 1 cycle, div/rem in XLEN+1 cycles.
// A result is held on res_o until out_ready_i; in_ready_o drops while dividing or while a held result is not being drained.
module bitmanip_exec_unit #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [4:0]      alu_op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] ex_mem_i,
   input  logic [XLEN-1:0] mem_wb_i,
   input  logic [1:0]      op1_sel_i,
   input  logic [1:0]      op2_sel_i,
   input  logic            imm_sel_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] res_o
);
   localparam logic [4:0] OP_CLZ   = 5'b00001, OP_CTZ  = 5'b00010, OP_CPOP  = 5'b00011;
   localparam logic [4:0] OP_MINU  = 5'b00100, OP_MAXU = 5'b00101, OP_SEXTH = 5'b00110;
   localparam logic [4:0] OP_SEXTB = 5'b00111, OP_MAX  = 5'b01000, OP_MIN   = 5'b01001;
   localparam logic [4:0] OP_ZEXTH = 5'b01010, OP_ROL  = 5'b01011, OP_ROR   = 5'b01100;
   localparam logic [4:0] OP_ORCB  = 5'b01110, OP_REV8 = 5'b01111, OP_ANDN  = 5'b10000;
   localparam logic [4:0] OP_ORN   = 5'b10001, OP_XNOR = 5'b10010, OP_DIV   = 5'b10011;
   localparam logic [4:0] OP_DIVU  = 5'b10100, OP_REM  = 5'b10101, OP_REMU  = 5'b10110;

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t            state_q;
   logic              out_valid_q;
   logic [XLEN-1:0]   res_q;
   logic [SHW-1:0]    cnt_q;
   logic [XLEN-1:0]   rem_q, quo_q, dvsr_q, dvd_q;
   logic              qneg_q, rneg_q, isrem_q, div0_q;

   logic [XLEN-1:0]   op1, op2, alu_res_d, div_res_d, rem_d, quo_d;
   logic [XLEN-1:0]   clz_v, ctz_v, cpop_v, orcb_v, rev8_v;
   logic [2*XLEN-1:0] rol_w, ror_w;
   logic [XLEN:0]     partial, diff;
   logic              accept, is_div, is_signed, sgn1, sgn2;

   always_comb begin
      case (op1_sel_i)
         2'b00:   op1 = rs1_i;
         2'b01:   op1 = mem_wb_i;
         2'b10:   op1 = ex_mem_i;
         default: op1 = '0;
      endcase
      case (op2_sel_i)
         2'b00:   op2 = rs2_i;
         2'b01:   op2 = mem_wb_i;
         2'b10:   op2 = ex_mem_i;
         default: op2 = '0;
      endcase
      if (imm_sel_i) op2 = imm_i;
   end

   always_comb begin
      clz_v  = XLEN'(XLEN);
      ctz_v  = XLEN'(XLEN);
      cpop_v = '0;
      orcb_v = '0;
      rev8_v = '0;
      for (int i = 0; i < XLEN; i++) begin
         if (op1[i]) clz_v = XLEN'(XLEN - 1 - i);
         cpop_v = cpop_v + XLEN'(op1[i]);
      end
      for (int i = XLEN - 1; i >= 0; i--) begin
         if (op1[i]) ctz_v = XLEN'(i);
      end
      for (int b = 0; b < XLEN / 8; b++) begin
         orcb_v[8*b +: 8] = {8{|op1[8*b +: 8]}};
         rev8_v[8*b +: 8] = op1[XLEN-8-8*b +: 8];
      end
      // Rotating a doubled word lets a plain shift do the wrap-around.
      rol_w = {op1, op1} << op2[SHW-1:0];
      ror_w = {op1, op1} >> op2[SHW-1:0];
   end

   always_comb begin
      alu_res_d = '0;
      case (alu_op_i)
         OP_CLZ:   alu_res_d = clz_v;
         OP_CTZ:   alu_res_d = ctz_v;
         OP_CPOP:  alu_res_d = cpop_v;
         OP_MINU:  alu_res_d = (op1 < op2) ? op1 : op2;
         OP_MAXU:  alu_res_d = (op1 < op2) ? op2 : op1;
         OP_SEXTH: alu_res_d = {{(XLEN-16){op1[15]}}, op1[15:0]};
         OP_SEXTB: alu_res_d = {{(XLEN-8){op1[7]}}, op1[7:0]};
         OP_MAX:   alu_res_d = ($signed(op1) < $signed(op2)) ? op2 : op1;
         OP_MIN:   alu_res_d = ($signed(op1) < $signed(op2)) ? op1 : op2;
         OP_ZEXTH: alu_res_d = {{(XLEN-16){1'b0}}, op1[15:0]};
         OP_ROL:   alu_res_d = rol_w[2*XLEN-1:XLEN];
         OP_ROR:   alu_res_d = ror_w[XLEN-1:0];
         OP_ORCB:  alu_res_d = orcb_v;
         OP_REV8:  alu_res_d = rev8_v;
         OP_ANDN:  alu_res_d = op1 & ~op2;
         OP_ORN:   alu_res_d = op1 | ~op2;
         OP_XNOR:  alu_res_d = ~(op1 ^ op2);
         default:  alu_res_d = '0;
      endcase
   end

   assign is_div    = (alu_op_i == OP_DIV) || (alu_op_i == OP_DIVU) ||
                      (alu_op_i == OP_REM) || (alu_op_i == OP_REMU);
   assign is_signed = (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
   assign sgn1      = is_signed & op1[XLEN-1];
   assign sgn2      = is_signed & op2[XLEN-1];

   // Restoring step: shift the next dividend bit in, keep the difference if it did not go negative.
   assign partial = {rem_q, quo_q[XLEN-1]};
   assign diff    = partial - {1'b0, dvsr_q};
   assign rem_d   = diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
   assign quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};

   always_comb begin
      div_res_d = isrem_q ? (rneg_q ? -rem_d : rem_d) : (qneg_q ? -quo_d : quo_d);
      if (div0_q) div_res_d = isrem_q ? dvd_q : '1;
   end

   assign in_ready_o  = (state_q == IDLE) && (!out_valid_q || out_ready_i);
   assign accept      = in_valid_i && in_ready_o;
   assign out_valid_o = out_valid_q;
   assign res_o       = res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_q      <= '0;
         dvd_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         isrem_q     <= 1'b0;
         div0_q      <= 1'b0;
      end else if (flush_i) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && is_div) begin
                  state_q     <= DIV;
                  out_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  rem_q       <= '0;
                  quo_q       <= sgn1 ? -op1 : op1;
                  dvsr_q      <= sgn2 ? -op2 : op2;
                  dvd_q       <= op1;
                  qneg_q      <= sgn1 ^ sgn2;
                  rneg_q      <= sgn1;
                  isrem_q     <= (alu_op_i == OP_REM) || (alu_op_i == OP_REMU);
                  div0_q      <= (op2 == '0);
               end else if (accept) begin
                  res_q       <= alu_res_d;
                  out_valid_q <= 1'b1;
               end else if (out_ready_i) begin
                  out_valid_q <= 1'b0;
               end
            end
            DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == SHW'(XLEN - 1)) begin
                  state_q     <= DONE;
                  res_q       <= div_res_d;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bitmanip_exec_unit.sv
// Directed bench for bitmanip_exec_unit: a reference model checked every cycle plus hand-computed vectors.
module tb_bitmanip_exec_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [4:0]  alu_op = '0;
   logic [31:0] rs1 = '0, rs2 = '0, imm = '0, ex_mem = '0, mem_wb = '0;
   logic [1:0]  op1_sel = '0, op2_sel = '0;
   logic        imm_sel = 1'b0, flush = 1'b0, out_valid, out_ready = 1'b1;
   logic [31:0] res;

   logic        v_valid = 1'b0, v_ready, v_out_valid;
   logic [4:0]  v_op = '0;
   logic [63:0] v_rs1 = '0, v_rs2 = '0, v_res;
   logic [63:0] v_zero = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bitmanip_exec_unit u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .alu_op_i(alu_op), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .ex_mem_i(ex_mem),
      .mem_wb_i(mem_wb), .op1_sel_i(op1_sel), .op2_sel_i(op2_sel), .imm_sel_i(imm_sel),
      .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res)
   );

   bitmanip_exec_unit #(.XLEN(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(v_valid), .in_ready_o(v_ready),
      .alu_op_i(v_op), .rs1_i(v_rs1), .rs2_i(v_rs2), .imm_i(v_zero), .ex_mem_i(v_zero),
      .mem_wb_i(v_zero), .op1_sel_i(2'b00), .op2_sel_i(2'b00), .imm_sel_i(1'b0),
      .flush_i(1'b0), .out_valid_o(v_out_valid), .out_ready_i(1'b1), .res_o(v_res)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the operation definitions.
   function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      int n, sa, sb;
      r = '0; n = 0; sa = a; sb = b;
      case (op)
         5'd1:  begin while (n < 32 && !a[31-n]) n++; r = n; end
         5'd2:  begin while (n < 32 && !a[n]) n++; r = n; end
         5'd3:  r = $countones(a);
         5'd4:  r = (a < b) ? a : b;
         5'd5:  r = (a > b) ? a : b;
         5'd6:  r = (sa <<< 16) >>> 16;
         5'd7:  r = (sa <<< 24) >>> 24;
         5'd8:  r = (sa > sb) ? a : b;
         5'd9:  r = (sa < sb) ? a : b;
         5'd10: r = a & 32'h0000_FFFF;
         5'd11: begin n = b % 32; r = (a << n) | (a >> (32 - n)); end
         5'd12: begin n = b % 32; r = (a >> n) | (a << (32 - n)); end
         5'd14: for (int k = 0; k < 4; k++) r[8*k +: 8] = (a[8*k +: 8] != 0) ? 8'hFF : 8'h00;
         5'd15: r = {a[7:0], a[15:8], a[23:16], a[31:24]};
         5'd16: r = a & ~b;
         5'd17: r = a | ~b;
         5'd18: r = ~(a ^ b);
         5'd19: if (b == 0) r = '1; else if (a == 32'h8000_0000 && b == '1) r = a; else r = sa / sb;
         5'd20: r = (b == 0) ? '1 : a / b;
         5'd21: if (b == 0) r = a; else if (a == 32'h8000_0000 && b == '1) r = 0; else r = sa % sb;
         5'd22: r = (b == 0) ? a : a % b;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rs);
      case (s)
         2'b00:   return rs;
         2'b01:   return mem_wb;
         2'b10:   return ex_mem;
         default: return 32'h0;
      endcase
   endfunction

   logic        m_valid = 1'b0, m_from_div = 1'b0;
   logic [31:0] m_res = '0, m_div_res = '0;
   int          m_left = 0;

   function automatic logic m_ready();
      return (m_left == 0) && !(m_valid && m_from_div) && (!m_valid || out_ready);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0; m_res <= '0; m_left <= 0; m_from_div <= 1'b0; m_div_res <= '0;
      end else if (flush) begin
         m_valid <= 1'b0; m_left <= 0; m_from_div <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_valid <= 1'b1; m_res <= m_div_res; m_from_div <= 1'b1;
         end
      end else if (in_valid && m_ready()) begin
         if (alu_op inside {[5'd19:5'd22]}) begin
            m_left <= 32; m_valid <= 1'b0; m_from_div <= 1'b0;
            m_div_res <= ref_op(alu_op, pick(op1_sel, rs1), imm_sel ? imm : pick(op2_sel, rs2));
         end else begin
            m_valid <= 1'b1; m_from_div <= 1'b0;
            m_res <= ref_op(alu_op, pick(op1_sel, rs1), imm_sel ? imm : pick(op2_sel, rs2));
         end
      end else if (out_ready) begin
         m_valid <= 1'b0; m_from_div <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cmp_in_ready", in_ready, m_ready());
         chk("cmp_out_valid", out_valid, m_valid);
         if (m_valid) chk("cmp_res", res, m_res);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds in_valid until the unit takes the op; returns one cycle after the accepting edge.
   task automatic send_raw(input logic [4:0] op);
      logic ok;
      ok = 1'b0;
      alu_op = op;
      in_valid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = in_ready;
         step();
      end
      in_valid = 1'b0;
      rs1 = $urandom; rs2 = $urandom; imm = $urandom; mem_wb = $urandom; ex_mem = $urandom;
      chk("send_accepted", ok, 1'b1);
   endtask

   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      rs1 = a; rs2 = b; op1_sel = 2'b00; op2_sel = 2'b00; imm_sel = 1'b0;
      send_raw(op);
   endtask

   task automatic vec(input string name, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
      send(op, a, b);
      chk({name, "_valid"}, out_valid, 1'b1);
      chk(name, res, exp);
   endtask

   task automatic dvec(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
      int   c;
      logic busy_rdy;
      send(op, a, b);
      c = 1;
      busy_rdy = 1'b0;
      while (!out_valid && c < 100) begin
         if (in_ready) busy_rdy = 1'b1;
         step();
         c++;
      end
      if (in_ready) busy_rdy = 1'b1;
      chk({name, "_latency"}, c, 33);
      chk({name, "_busy_ready"}, busy_rdy, 1'b0);
      chk(name, res, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int   c;
      logic seen;
      logic [31:0] held;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_res", res, 32'h0);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_valid64", v_out_valid, 1'b0);
      rst_n = 1'b1;
      step();

      vec("clz_8000",   5'b00001, 32'h0000_8000, 32'h0, 32'd16);
      vec("ctz_zero",   5'b00010, 32'h0000_0000, 32'h0, 32'd32);
      vec("cpop",       5'b00011, 32'hF0F0_0001, 32'h0, 32'd9);
      vec("clz_ones",   5'b00001, 32'hFFFF_FFFF, 32'h0, 32'd0);
      vec("ctz_msb",    5'b00010, 32'h8000_0000, 32'h0, 32'd31);
      vec("ror_1",      5'b01100, 32'h8000_0001, 32'd1, 32'hC000_0000);
      vec("ror_33",     5'b01100, 32'h8000_0001, 32'd33, 32'hC000_0000);
      vec("rol_0",      5'b01011, 32'h1234_5678, 32'd0, 32'h1234_5678);
      vec("rol_4",      5'b01011, 32'h8000_0001, 32'd4, 32'h0000_0018);
      vec("andn",       5'b10000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF000_F000);
      vec("orn",        5'b10001, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_FFFF);
      vec("xnor",       5'b10010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF00F_F00F);
      vec("orc_b",      5'b01110, 32'h0010_0000, 32'h0, 32'h00FF_0000);
      vec("rev8",       5'b01111, 32'h0102_0304, 32'h0, 32'h0403_0201);
      vec("sext_b",     5'b00111, 32'h1234_5680, 32'h0, 32'hFFFF_FF80);
      vec("sext_h_neg", 5'b00110, 32'h0000_8001, 32'h0, 32'hFFFF_8001);
      vec("sext_h_pos", 5'b00110, 32'hFFFF_7FFF, 32'h0, 32'h0000_7FFF);
      vec("zext_h",     5'b01010, 32'hABCD_1234, 32'h0, 32'h0000_1234);
      vec("max",        5'b01000, 32'hFFFF_FFFF, 32'd1, 32'd1);
      vec("min",        5'b01001, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
      vec("maxu",       5'b00101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
      vec("minu",       5'b00100, 32'hFFFF_FFFF, 32'd1, 32'd1);
      vec("op_zero",    5'b00000, 32'hFFFF_FFFF, 32'h1, 32'h0);
      vec("op_01101",   5'b01101, 32'hFFFF_FFFF, 32'h1, 32'h0);
      vec("op_10111",   5'b10111, 32'hFFFF_FFFF, 32'h1, 32'h0);
      vec("op_11111",   5'b11111, 32'hFFFF_FFFF, 32'h1, 32'h0);

      // Forwarded operands and immediate override.
      mem_wb = 32'hFFFF_FFFF; imm = 32'h0000_FFFF; rs2 = 32'h0;
      op1_sel = 2'b01; op2_sel = 2'b00; imm_sel = 1'b1;
      send_raw(5'b10000);
      chk("fwd_wb_imm", res, 32'hFFFF_0000);
      ex_mem = 32'h0000_0F00; mem_wb = 32'h0000_00F0;
      op1_sel = 2'b10; op2_sel = 2'b01; imm_sel = 1'b0;
      send_raw(5'b10010);
      chk("fwd_exm_wb", res, 32'hFFFF_F00F);
      rs1 = 32'hFFFF_FFFF; ex_mem = 32'h1234_5678;
      op1_sel = 2'b11; op2_sel = 2'b10;
      send_raw(5'b00101);
      chk("fwd_zero_exm", res, 32'h1234_5678);

      dvec("div_m7_2",   5'b10011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      dvec("rem_m7_2",   5'b10101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      dvec("div_7_m2",   5'b10011, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      dvec("rem_7_m2",   5'b10101, 32'd7, 32'hFFFF_FFFE, 32'd1);
      dvec("divu_5_0",   5'b10100, 32'd5, 32'd0, 32'hFFFF_FFFF);
      dvec("remu_5_0",   5'b10110, 32'd5, 32'd0, 32'd5);
      dvec("div_m7_0",   5'b10011, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
      dvec("rem_m7_0",   5'b10101, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
      dvec("rem_ovf",    5'b10101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
      dvec("div_ovf",    5'b10011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      dvec("divu_big",   5'b10100, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999);
      dvec("remu_big",   5'b10110, 32'hFFFF_FFFF, 32'd10, 32'd5);

      // Backpressure: result held, new op stalled until out_ready_i rises.
      step();
      out_ready = 1'b0;
      send(5'b00011, 32'h0000_00FF, 32'h0);
      held = res;
      chk("bp_first_res", held, 32'd8);
      rs1 = 32'h1; op1_sel = 2'b00; imm_sel = 1'b0; alu_op = 5'b00001; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_hold_valid", out_valid, 1'b1);
         chk("bp_hold_res", res, held);
         chk("bp_hold_ready", in_ready, 1'b0);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      chk("bp_next_valid", out_valid, 1'b1);
      chk("bp_next_res", res, 32'd31);

      // Flush during a divide.
      step();
      send(5'b10100, 32'd100, 32'd7);
      repeat (9) step();
      flush = 1'b1; rs1 = 32'h1; alu_op = 5'b00001; in_valid = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_in_ready", in_ready, 1'b1);
      chk("flush_out_valid", out_valid, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid) seen = 1'b1;
         step();
      end
      chk("flush_never_valid", seen, 1'b0);

      // Asynchronous reset in the middle of a divide.
      vec("pre_reset_clz", 5'b00001, 32'h1, 32'h0, 32'd31);
      send(5'b10011, 32'd100, 32'd7);
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_res", res, 32'h0);
      chk("arst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      vec("post_reset_clz", 5'b00001, 32'h0001_0000, 32'h0, 32'd15);

      // 64-bit instance.
      step();
      chk("x64_ready", v_ready, 1'b1);
      v_op = 5'b01111; v_rs1 = 64'h0102_0304_0506_0708; v_valid = 1'b1;
      step();
      v_valid = 1'b0;
      chk("x64_rev8_valid", v_out_valid, 1'b1);
      chk("x64_rev8", v_res, 64'h0807_0605_0403_0201);
      v_op = 5'b10100; v_rs1 = 64'd1000; v_rs2 = 64'd10; v_valid = 1'b1;
      step();
      v_valid = 1'b0; v_rs1 = '1; v_rs2 = '1;
      c = 1;
      while (!v_out_valid && c < 200) begin
         step();
         c++;
      end
      chk("x64_divu_latency", c, 65);
      chk("x64_divu", v_res, 64'd100);

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bitmanip_exec_unit.md
BITMANIP_EXEC_UNIT -- requirements
Module: bitmanip_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid_i  input  1  operation request valid.
REQ-006 in_ready_o  output  1  unit can accept an operation this cycle.
REQ-007 alu_op_i  input  5  operation code (REQ-015).
REQ-008 rs1_i, rs2_i, imm_i, ex_mem_i, mem_wb_i  input  XLEN each  register, immediate and forwarded operands.
REQ-009 op1_sel_i, op2_sel_i  input  2 each  operand select: 00 rs, 01 mem_wb, 10 ex_mem, 11 zero.
REQ-010 imm_sel_i  input  1  1 = operand2 is imm_i, overriding op2_sel_i.
REQ-011 flush_i  input  1  synchronous kill of in-flight and pending result.
REQ-012 out_valid_o  output  1  result valid.
REQ-013 out_ready_i  input  1  consumer accepts result.
REQ-014 res_o  output  XLEN  result; held stable while out_valid_o=1 and out_ready_i=0.

Function
REQ-015 Opcodes: 00000 zero; 00001 clz; 00010 ctz; 00011 cpop; 00100 minu; 00101 maxu; 00110 sext.h; 00111 sext.b; 01000 max; 01001 min; 01010 zext.h; 01011 rol; 01100 ror; 01110 orc.b; 01111 rev8; 10000 andn; 10001 orn; 10010 xnor; 10011 div; 10100 divu; 10101 rem; 10110 remu; others -> result 0, single-cycle.
REQ-016 Operands muxed combinationally from inputs sampled on the accept cycle, then captured; later input changes do not affect an accepted op.
REQ-017 andn = op1 & ~op2; orn = op1 | ~op2; xnor = ~(op1 ^ op2).
REQ-018 rol/ror rotate op1 by op2[SHW-1:0]; amount 0 returns op1 unchanged.
REQ-019 clz/ctz of zero = XLEN; clz/ctz/cpop zero-extended to XLEN.
REQ-020 orc.b: each byte 0x00 if zero else 0xFF; rev8 reverses all XLEN/8 bytes.
REQ-021 sext.h/sext.b sign-extend to XLEN; zext.h zero-extends bits [15:0].
REQ-022 FSM states IDLE, DIV, DONE; reset state IDLE.
REQ-023 in_ready_o = (state==IDLE) and (out_valid_o=0 or out_ready_i=1).
REQ-024 Accept = in_valid_i and in_ready_o; non-divide op: res_o registered, out_valid_o=1 next cycle (latency 1), state stays IDLE.
REQ-025 Divide op: IDLE->DIV; restoring divider, one quotient bit per cycle, XLEN cycles; DIV->DONE with out_valid_o=1; accept at cycle 0 -> out_valid_o at cycle XLEN+1.
REQ-026 DONE->IDLE on out_ready_i=1; back-to-back single-cycle ops sustain one per cycle when out_ready_i=1.
REQ-027 Signed div/rem: divide magnitudes, quotient negated if signs differ, remainder takes dividend sign.
REQ-028 Divisor 0: quotient all ones, remainder = dividend; still XLEN+1 latency.
REQ-029 Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder 0.
REQ-030 out_valid_o=1 and out_ready_i=0: res_o, out_valid_o held; in_ready_o=0.
REQ-031 flush_i=1: next cycle state IDLE, out_valid_o=0; an op presented with flush_i=1 is not accepted; flush has priority over accept and completion.

Reset
REQ-032 rst_n=0 immediately forces state IDLE, out_valid_o=0, res_o=0, divider counter/registers 0, regardless of clk.
REQ-033 Reset during DIV discards the operation; first accept possible on first rising edge after rst_n=1.

Verification
REQ-034 XLEN=32, clz op1=0x0000_8000, ctz op1=0, cpop op1=0xF0F0_0001 -> res_o 16, 32, 9, each one cycle after accept.
REQ-035 ror op1=0x8000_0001 amt 1 -> 0xC000_0000; rol amt 0 -> unchanged; andn 0xFF00_FF00,0x0F0F_0F0F -> 0xF000_F000; orc.b 0x0010_0000 -> 0x00FF_0000.
REQ-036 div -7/2 -> -3 at cycle 33; rem -7/2 -> -1; divu 5/0 -> 0xFFFF_FFFF; rem 0x8000_0000/-1 -> 0; in_ready_o=0 throughout.
REQ-037 out_ready_i=0 for 5 cycles after result: res_o/out_valid_o stable, in_ready_o=0; then out_ready_i=1 -> new op accepted same cycle.
REQ-038 flush_i at cycle 10 of divu -> out_valid_o never asserts for it, in_ready_o=1 next cycle; rst_n low mid-DIV -> outputs 0 asynchronously.
REQ-039 XLEN=64: rev8 0x0102_0304_0506_0708 -> 0x0807_0605_0403_0201; divu latency 65 cycles.
